// File: rtl/seq_div32.sv
// Iterative radix-2 restoring divider, one trial subtract per cycle, start/busy/done handshake.
// Optional two's-complement operation is enabled by defining SEQ_DIV_SIGNED_EN.
module seq_div32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] q_reg, r_reg, dvs_reg;
  logic             dbz_reg;
  logic             last_step;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] r_sh, q_sh, r_nx, q_nx;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] q_fin, r_fin;

`ifdef SEQ_DIV_SIGNED_EN
  logic sign_q, sign_r;

  always_comb begin
    a_mag = dividend[WIDTH-1] ? -dividend : dividend;
    b_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
    q_fin = sign_q ? -q_nx : q_nx;
    r_fin = sign_r ? -r_nx : r_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else if (state == IDLE && start) begin
      sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      sign_r <= dividend[WIDTH-1];
    end
  end
`else
  always_comb begin
    a_mag = dividend;
    b_mag = divisor;
    q_fin = q_nx;
    r_fin = r_nx;
  end
`endif

  // One restoring step: shift the next dividend bit into r, trial subtract, keep if non-negative.
  always_comb begin
    r_sh  = {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};
    q_sh  = {q_reg[WIDTH-2:0], 1'b0};
    trial = {1'b0, r_sh} - {1'b0, dvs_reg};
    if (!trial[WIDTH]) begin
      r_nx = trial[WIDTH-1:0];
      q_nx = q_sh | WIDTH'(1);
    end else begin
      r_nx = r_sh;
      q_nx = q_sh;
    end
  end

  // A zero divisor spends a single cycle in CALC so its done lands one edge after acceptance.
  assign last_step = dbz_reg || (count == CW'(WIDTH-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    if (last_step) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count       <= '0;
      q_reg       <= '0;
      r_reg       <= '0;
      dvs_reg     <= '0;
      dbz_reg     <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          count   <= '0;
          r_reg   <= '0;
          dvs_reg <= b_mag;
          dbz_reg <= (divisor == '0);
          // Raw dividend kept for the zero-divisor case, it becomes the remainder unchanged.
          q_reg   <= (divisor == '0) ? dividend : a_mag;
        end
        CALC: begin
          if (dbz_reg) begin
            quotient    <= '1;
            remainder   <= q_reg;
            div_by_zero <= 1'b1;
          end else begin
            q_reg <= q_nx;
            r_reg <= r_nx;
            count <= count + CW'(1);
            if (last_step) begin
              quotient    <= q_fin;
              remainder   <= r_fin;
              div_by_zero <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div32.sv
// Scoreboard bench for seq_div32: stimulus pushes expected results, a negedge monitor checks each done.
// Signed vectors run only when SEQ_DIV_SIGNED_EN is defined.
module tb_seq_div32;

  logic        clk, rst, start;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc;
  int unsigned npass, ntot;

  seq_div32 #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.z});
        chk("latency", cyc, e.cyc);
      end
    end
  end

  task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er,
                        input logic ez, input bit spam);
    int unsigned n;
    bit          busy_ok;
    exp_t        e;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    e.q   = eq;
    e.r   = er;
    e.z   = ez;
    e.cyc = cyc + ((b == 32'd0) ? 2 : 33);
    sb.push_back(e);
    @(negedge clk);
    busy_ok = 1'b1;
    n = 0;
    while (!done && n < 100) begin
      busy_ok &= busy;
      if (spam) begin
        start    = 1'b1;
        dividend = $urandom;
        divisor  = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("done_seen", {31'd0, done}, 32'd1);
    chk("busy_held", {31'd0, busy_ok & busy}, 32'd1);
    @(negedge clk);
    chk("idle_after_done", {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    bit saw;
    cyc = 0; npass = 0; ntot = 0;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    chk("reset_quotient", quotient, 32'd0);
    chk("reset_remainder", remainder, 32'd0);
    chk("reset_flags", {29'd0, busy, done, div_by_zero}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("quotient_held", quotient, 32'd14);
    do_div(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    do_div(32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 1'b0);
    do_div(32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1'b0);
    do_div(32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 1'b0);
    do_div(32'd1000000, 32'd1000, 32'd1000, 32'd0, 1'b0, 1'b0);
    do_div(32'h7FFF_FFFF, 32'h0001_0000, 32'h0000_7FFF, 32'h0000_FFFF, 1'b0, 1'b0);
    do_div(32'h1234_5678, 32'h0000_0100, 32'h0012_3456, 32'h0000_0078, 1'b0, 1'b0);
    do_div(32'd200, 32'd9, 32'd22, 32'd2, 1'b0, 1'b1);

    // Abort mid-calculation: outputs clear asynchronously and no done follows.
    start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_outputs", quotient | remainder, 32'd0);
    chk("abort_flags", {29'd0, busy, done, div_by_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      saw |= done;
    end
    chk("no_done_after_abort", {31'd0, saw}, 32'd0);
    do_div(32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 1'b0);

`ifdef SEQ_DIV_SIGNED_EN
    do_div(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_div(32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
    do_div(32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1'b0);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
